fifo_cache_to_main: RTL

Write-back buffer between the cache and main memory: the opposite direction to the main-to-cache fill path. It queues evicted dirty 512-bit lines with their line addresses, drains them one at a time to main memory over a req/ack handshake, and merges repeated write-backs to the same line. It also provides a combinational address lookup so the cache can forward a line that is still queued.

---
 rtl/fifo_cache_to_main.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fifo_cache_to_main.sv
// Write-back buffer from the cache to main memory. Dirty lines are queued
// in a circular buffer, merged when the same line is evicted again, and
// drained one at a time over a req/ack handshake. A combinational lookup
// lets the cache forward a line that has not yet reached memory.
//
// Handshakes:
//   wb side  : a line is taken on any posedge where wb_valid && wb_ready.
//              wb_ready is ~full and never depends on this cycle's pop.
//   mem side : mem_req/mem_addr/mem_data are registered and hold steady
//              until mem_ack is sampled high; that edge retires the line.
module fifo_cache_to_main #(
  parameter int FIFO_WIDTH = 512,
  parameter int ADDR_WIDTH = 26,
  parameter int DEPTH      = 8,
  parameter int PTR_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  input  logic [FIFO_WIDTH-1:0] wb_data,
  output logic                  wb_ready,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [FIFO_WIDTH-1:0] mem_data,
  input  logic                  mem_ack,
  input  logic [ADDR_WIDTH-1:0] lookup_addr,
  output logic                  lookup_hit,
  output logic [FIFO_WIDTH-1:0] lookup_data,
  output logic                  full,
  output logic                  empty,
  output logic [PTR_WIDTH:0]    count
);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [FIFO_WIDTH-1:0] data_mem [DEPTH];
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  off;
  logic [DEPTH-1:0]      occupied;
  logic [DEPTH-1:0]      in_flight;
  logic                  push;
  logic                  pop;
  logic                  append;
  logic                  coal_hit;
  logic [PTR_WIDTH-1:0]  coal_idx;
  logic [FIFO_WIDTH-1:0] head_data;

  assign full     = (count == (PTR_WIDTH+1)'(DEPTH));
  assign empty    = (count == '0);
  assign wb_ready = ~full;
  assign push     = wb_valid & wb_ready;
  assign append   = push & ~coal_hit;
  assign pop      = (state == S_SEND) & mem_ack;

  // A merge into the head in the same edge the head is launched must be
  // launched with the new data, otherwise the merged data would be lost.
  assign head_data = (push && coal_hit && (coal_idx == rd_ptr)) ? wb_data : data_mem[rd_ptr];

  // Mark which slots hold live entries and which one is being transferred.
  always_comb begin
    occupied  = '0;
    in_flight = '0;
    off       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off          = PTR_WIDTH'(i) - rd_ptr;
      occupied[i]  = ({1'b0, off} < count);
      in_flight[i] = (state == S_SEND) && (PTR_WIDTH'(i) == rd_ptr);
    end
  end

  // Find a live, not-in-flight entry with the incoming address to merge into.
  always_comb begin
    coal_hit = 1'b0;
    coal_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (occupied[i] && !in_flight[i] && (addr_mem[i] == wb_addr)) begin
        coal_hit = 1'b1;
        coal_idx = PTR_WIDTH'(i);
      end
    end
  end

  // Lookup: a queued (not in flight) copy is newer than the in-flight head.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (occupied[i] && !in_flight[i] && (addr_mem[i] == lookup_addr)) begin
        lookup_hit  = 1'b1;
        lookup_data = data_mem[i];
      end
    end
    if (!lookup_hit && (state == S_SEND) && (addr_mem[rd_ptr] == lookup_addr)) begin
      lookup_hit  = 1'b1;
      lookup_data = data_mem[rd_ptr];
    end
  end

  // Entry storage: merge overwrites data in place, append writes at wr_ptr.
  always_ff @(posedge clk) begin
    if (push) begin
      if (coal_hit) begin
        data_mem[coal_idx] <= wb_data;
      end else begin
        addr_mem[wr_ptr] <= wb_addr;
        data_mem[wr_ptr] <= wb_data;
      end
    end
  end

  // Pointers, occupancy and the two-state drain FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      state    <= S_IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      mem_data <= '0;
    end else begin
      if (append) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({append, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
      case (state)
        S_IDLE: begin
          if (count != '0) begin
            mem_addr <= addr_mem[rd_ptr];
            mem_data <= head_data;
            mem_req  <= 1'b1;
            state    <= S_SEND;
          end
        end
        S_SEND: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
